// File: rtl/adder_sum_accum.sv
// adder_sum_accum: accumulates groups of 5-bit adder sums into an ACC_W-bit
// total. A group closes on in_last or after MAX_TERMS accepted sums, and the
// result is presented with a valid/ready handshake.
// Optional build macro: ADDER_SUM_ACCUM_SATURATE_EN (clamp instead of wrap).
module adder_sum_accum #(
  parameter  int ACC_W     = 8,
  parameter  int MAX_TERMS = 16,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_acc_q, res_acc_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_ovf_q, res_ovf_d;

  logic               accept;
  logic               first;
  logic [ACC_W:0]     sum_w;
  logic               carry;
  logic [ACC_W-1:0]   acc_add;
  logic [CNT_W-1:0]   cnt_add;
  logic               ovf_add;
  logic               close;

  // Handshake outputs are pure state decodes.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign first     = (state_q == IDLE);

  // Datapath: candidate next total/count/overflow if this sum is accepted.
  always_comb begin
    sum_w   = {1'b0, (first ? '0 : acc_q)} + (ACC_W + 1)'(in_sum);
    carry   = sum_w[ACC_W];
`ifdef ADDER_SUM_ACCUM_SATURATE_EN
    acc_add = carry ? '1 : sum_w[ACC_W-1:0];
`else
    acc_add = sum_w[ACC_W-1:0];
`endif
    cnt_add = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    ovf_add = first ? carry : (ovf_q | carry);
    // Closing is judged on the incremented count so count never exceeds MAX_TERMS.
    close   = in_last || (cnt_add == CNT_W'(MAX_TERMS));
  end

  // Next-state logic: load/accumulate on accept, publish result on close,
  // clear everything when the consumer takes the result.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_acc_d = res_acc_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_add;
          ovf_d = ovf_add;
          if (close) begin
            state_d   = HOLD;
            res_acc_d = acc_add;
            res_cnt_d = cnt_add;
            res_ovf_d = ovf_add;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          res_acc_d = '0;
          res_cnt_d = '0;
          res_ovf_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_acc_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_acc_q <= res_acc_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Result outputs come straight from registers that read 0 outside HOLD.
  assign out_acc   = res_acc_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

endmodule
